// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment display path.
// This package also holds the decode helpers used by the scan readback block.
package seg_scan_decoder_pkg;

  // Active-low segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef enum logic {COLLECT, CONV} state_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } an_dec_t;

  // Maps a one-hot-low digit enable to its digit position.
  function automatic an_dec_t an_decode(input logic [3:0] an);
    an_dec_t r;
    r.ok  = 1'b1;
    r.idx = 2'd0;
    case (an)
      AN_DIG0: r.idx = 2'd0;
      AN_DIG1: r.idx = 2'd1;
      AN_DIG2: r.idx = 2'd2;
      AN_DIG3: r.idx = 2'd3;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD digit decode.
// ok_o is low for any pattern outside the ten digit glyphs.
module seg7_to_bcd
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       ok_o,
  output logic [3:0] digit_o
);

  always_comb begin
    ok_o    = 1'b1;
    digit_o = 4'd0;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: ok_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the displayed value from the multiplexed seg/an bus: debounces each
// digit, sequences a 4-digit frame and converts BCD to binary by shift-add.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int MIN_STABLE = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [13:0] number,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        frame_err,
  output logic        blank
);

  localparam int SCW = $clog2(MIN_STABLE + 1);
  localparam int TCW = $clog2(TIMEOUT);
  localparam logic [SCW-1:0] CAP_CNT = SCW'(MIN_STABLE - 1);
  localparam logic [SCW-1:0] SAT_CNT = SCW'(MIN_STABLE);
  localparam logic [TCW-1:0] TO_CNT  = TCW'(TIMEOUT - 1);

  logic [6:0]       seg_q;
  logic [3:0]       an_q;
  logic [SCW-1:0]   stab_q, stab_d;
  logic [TCW-1:0]   idle_q, idle_d;
  logic [1:0]       exp_q, exp_d;
  logic             sync_q, sync_d;
  logic [2:0][3:0]  dig_q, dig_d;
  logic [15:0]      conv_q, conv_d;
  logic [15:0]      snap_q, snap_d;
  logic             pend_q, pend_d;
  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [13:0]      acc_q, acc_d;
  logic [13:0]      number_q, number_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             blank_q, blank_d;

  logic             capture;
  logic             complete;
  logic             timeout;
  logic             seg_ok;
  logic [3:0]       seg_dig;
  an_dec_t          an_dec;
  logic [15:0]      frame_word;
  logic [3:0]       cur_dig;
  logic [13:0]      acc_step;

  seg7_to_bcd u_dec (
    .seg_i   (seg_q),
    .ok_o    (seg_ok),
    .digit_o (seg_dig)
  );

  assign an_dec = an_decode(an_q);

  // Saturating at MIN_STABLE makes the capture a single-cycle event per window.
  always_comb begin
    stab_d = stab_q;
    if (({an, seg} != {an_q, seg_q}) || (an == AN_OFF)) begin
      stab_d = '0;
    end else if (stab_q != SAT_CNT) begin
      stab_d = stab_q + 1'b1;
    end
  end

  assign capture = (stab_q == CAP_CNT);

  always_comb begin
    exp_d    = exp_q;
    sync_d   = sync_q;
    dig_d    = dig_q;
    err_d    = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    idle_d   = idle_q + 1'b1;
    if (capture) begin
      idle_d = '0;
      if (!an_dec.ok || !seg_ok) begin
        err_d = 1'b1;
        exp_d = 2'd0;
      end else if (an_dec.idx == exp_q) begin
        sync_d = 1'b1;
        exp_d  = an_dec.idx + 2'd1;
        case (an_dec.idx)
          2'd0:    dig_d[0] = seg_dig;
          2'd1:    dig_d[1] = seg_dig;
          2'd2:    dig_d[2] = seg_dig;
          default: complete = 1'b1;
        endcase
      end else begin
        // Before the first digit 0 is seen, out-of-order digits are expected noise.
        err_d = sync_q;
        if (an_dec.idx == 2'd0) begin
          dig_d[0] = seg_dig;
          exp_d    = 2'd1;
        end else begin
          exp_d = 2'd0;
        end
      end
    end else if (idle_q == TO_CNT) begin
      timeout = 1'b1;
      idle_d  = '0;
      exp_d   = 2'd0;
      sync_d  = 1'b0;
    end
  end

  assign frame_word = {seg_dig, dig_q[2], dig_q[1], dig_q[0]};
  assign cur_dig    = conv_q[{~step_q, 2'b00} +: 4];
  assign acc_step   = (acc_q << 3) + (acc_q << 1) + {10'd0, cur_dig};

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    acc_d    = acc_q;
    conv_d   = conv_q;
    snap_d   = snap_q;
    pend_d   = pend_q;
    number_d = number_q;
    bcd_d    = bcd_q;
    valid_d  = 1'b0;
    blank_d  = blank_q;
    if (timeout) blank_d = 1'b1;
    case (state_q)
      COLLECT: begin
        if (complete) begin
          conv_d  = frame_word;
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = CONV;
        end
      end
      default: begin
        acc_d  = acc_step;
        step_d = step_q + 2'd1;
        if (complete) begin
          snap_d = frame_word;
          pend_d = 1'b1;
        end
        if (step_q == 2'd3) begin
          number_d = acc_step;
          bcd_d    = conv_q;
          valid_d  = 1'b1;
          blank_d  = 1'b0;
          acc_d    = '0;
          if (complete) begin
            conv_d = frame_word;
            pend_d = 1'b0;
          end else if (pend_q) begin
            conv_d = snap_q;
            pend_d = 1'b0;
          end else begin
            state_d = COLLECT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= 7'h7F;
      an_q     <= AN_OFF;
      stab_q   <= '0;
      idle_q   <= '0;
      exp_q    <= 2'd0;
      sync_q   <= 1'b0;
      pend_q   <= 1'b0;
      state_q  <= COLLECT;
      step_q   <= 2'd0;
      number_q <= '0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      blank_q  <= 1'b1;
    end else begin
      seg_q    <= seg;
      an_q     <= an;
      stab_q   <= stab_d;
      idle_q   <= idle_d;
      exp_q    <= exp_d;
      sync_q   <= sync_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      step_q   <= step_d;
      number_q <= number_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      blank_q  <= blank_d;
    end
  end

  // Datapath storage is always overwritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    dig_q  <= dig_d;
    conv_q <= conv_d;
    snap_q <= snap_d;
    acc_q  <= acc_d;
  end

  assign number    = number_q;
  assign bcd       = bcd_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of display scans plus hand-built
// sequences for glitches, ordering errors, timeout, latency and reset.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'b1111;
  logic [13:0] number;
  logic [15:0] bcd;
  logic        valid;
  logic        frame_err;
  logic        blank;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  seg_scan_decoder #(.MIN_STABLE(4), .TIMEOUT(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .number    (number),
    .bcd       (bcd),
    .valid     (valid),
    .frame_err (frame_err),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] digits;
    logic [13:0] num;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Called at posedge+1; changes inputs there and returns at posedge+1.
  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show_digit(input int k, input logic [15:0] v);
    logic [3:0] d;
    d = v[4*k +: 4];
    show(an_of(k), pat(d), 80);
    show(4'b1111, 7'h7F, 10);
  endtask

  task automatic scan(input logic [15:0] v);
    for (int k = 0; k < 4; k++) show_digit(k, v);
  endtask

  int v0, e0, hits, pos;
  logic [15:0] v;

  initial begin
    vecs[0] = '{16'h1234, 14'd1234};
    vecs[1] = '{16'h9999, 14'd9999};
    vecs[2] = '{16'h0000, 14'd0};
    vecs[3] = '{16'h5678, 14'd5678};
    vecs[4] = '{16'h0909, 14'd909};
    vecs[5] = '{16'h8001, 14'd8001};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_number", number, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_valid", valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_blank", blank, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      scan(vecs[i].digits);
      chk("tbl_number", number, vecs[i].num);
      chk("tbl_bcd", bcd, vecs[i].digits);
      chk("tbl_valid_once", valid_cnt - v0, 1);
      chk("tbl_no_err", err_cnt - e0, 0);
      if (i == 0) chk("blank_cleared", blank, 0);
    end

    // Short glitch on digit 0 inside a gap of a 0042 scan.
    v0 = valid_cnt; e0 = err_cnt;
    v = 16'h0042;
    show(an_of(0), pat(4'd2), 80);
    show(4'b1111, 7'h7F, 4);
    show(4'b1110, 7'h78, 2);
    show(4'b1111, 7'h7F, 4);
    for (int k = 1; k < 4; k++) show_digit(k, v);
    chk("glitch_number", number, 42);
    chk("glitch_bcd", bcd, 16'h0042);
    chk("glitch_no_err", err_cnt - e0, 0);
    chk("glitch_valid", valid_cnt - v0, 1);

    // Order 0,1,3 then a clean frame.
    v0 = valid_cnt; e0 = err_cnt;
    v = 16'h8888;
    show_digit(0, v);
    show_digit(1, v);
    show_digit(3, v);
    chk("order_err", err_cnt - e0, 1);
    chk("order_no_valid", valid_cnt - v0, 0);
    scan(16'h2468);
    chk("order_recover_num", number, 2468);
    chk("order_recover_valid", valid_cnt - v0, 1);
    chk("order_recover_err", err_cnt - e0, 1);

    // Bad segment pattern and non-one-hot enables.
    v0 = valid_cnt; e0 = err_cnt;
    show(4'b1101, 7'h7F, 10);
    show(4'b1111, 7'h7F, 10);
    chk("badseg_err", err_cnt - e0, 1);
    show(4'b1100, 7'h12, 10);
    show(4'b1111, 7'h7F, 10);
    chk("badan_err", err_cnt - e0, 2);
    chk("bad_bcd_kept", bcd, 16'h2468);
    chk("bad_no_valid", valid_cnt - v0, 0);

    // Idle timeout.
    show(4'b1111, 7'h7F, 1000);
    chk("pre_timeout_blank", blank, 0);
    show(4'b1111, 7'h7F, 100);
    chk("timeout_blank", blank, 1);
    chk("timeout_number_kept", number, 2468);
    e0 = err_cnt; v0 = valid_cnt;
    show_digit(3, 16'h1000);
    chk("silent_resync", err_cnt - e0, 0);
    scan(16'h0007);
    chk("post_timeout_num", number, 7);
    chk("post_timeout_blank", blank, 0);
    chk("post_timeout_valid", valid_cnt - v0, 1);

    // Exact latency: valid 5 cycles after the digit-3 capture cycle.
    v = 16'h1357;
    for (int k = 0; k < 3; k++) show_digit(k, v);
    an = an_of(3);
    seg = pat(4'd1);
    hits = 0; pos = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        hits++;
        pos = i;
      end
    end
    chk("lat_hits", hits, 1);
    chk("lat_pos", pos, 9);
    chk("lat_number", number, 1357);
    show(4'b1111, 7'h7F, 10);

    // Reset two cycles into conversion.
    v = 16'h4321;
    for (int k = 0; k < 3; k++) show_digit(k, v);
    an = an_of(3);
    seg = pat(4'd4);
    repeat (7) @(posedge clk);
    #1;
    v0 = valid_cnt;
    rst_n = 1'b0;
    #1;
    chk("conv_rst_number", number, 0);
    chk("conv_rst_blank", blank, 1);
    chk("conv_rst_valid", valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    show(4'b1111, 7'h7F, 20);
    chk("conv_rst_no_valid", valid_cnt - v0, 0);
    chk("conv_rst_number_after", number, 0);
    chk("conv_rst_bcd_after", bcd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
